// File: rtl/tiny_dnn_csr_pkg.sv
// Shared constants for the tiny-dnn control/status register block.
package tiny_dnn_csr_pkg;

  // Register word offsets (byte address >> 2)
  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_IRQ_EN   = 2;
  localparam int REG_IRQ_STAT = 3;
  localparam int REG_CFG_BASE = 4;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_WWRITE = 1;
  localparam int CTRL_BWRITE = 2;

  // IRQ_EN / IRQ_STAT bit positions
  localparam int IRQ_DONE      = 0;
  localparam int IRQ_START_ERR = 1;

  // Expand a 4-bit byte strobe into a 32-bit bit mask
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

endpackage

// File: rtl/tiny_dnn_csr_axil.sv
// AXI4-Lite slave front end: holds AW and W independently, issues one
// register write when both are available, and registers read responses.
module tiny_dnn_csr_axil
  import tiny_dnn_csr_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [31:0]       s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  // rdy_q keeps every READY low while in reset and releases one cycle after
  logic              rdy_q, rdy_d;
  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              w_held_q, w_held_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              aw_hs, w_hs;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{s_awaddr[31:ADDR_W], s_araddr[31:ADDR_W]};

  assign s_awready = rdy_q & ~aw_held_q;
  assign s_wready  = rdy_q & ~w_held_q;
  assign s_arready = rdy_q & ~rvalid_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;

  // A handshake in the current cycle counts as held, so the write can
  // execute in the same cycle the second half arrives.
  assign wr_en   = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
  assign wr_addr = aw_held_q ? awaddr_q : s_awaddr[ADDR_W-1:0];
  assign wr_data = w_held_q ? wdata_q : s_wdata;
  assign wr_strb = w_held_q ? wstrb_q : s_wstrb;

  assign rd_en   = s_arvalid & s_arready;
  assign rd_addr = s_araddr[ADDR_W-1:0];

  // Next-state for holders and response channels
  always_comb begin
    rdy_d     = 1'b1;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_awaddr[ADDR_W-1:0];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_wdata;
      wstrb_d  = s_wstrb;
    end
    if (bvalid_q && s_bready) bvalid_d = 1'b0;
    if (wr_en) begin
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (rvalid_q && s_rready) rvalid_d = 1'b0;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err ? 32'h0 : rd_data;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // State registers; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rdy_q     <= rdy_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: rtl/tiny_dnn_csr.sv
// tiny-dnn CSR block: register file, address decode, start/irq logic.
module tiny_dnn_csr
  import tiny_dnn_csr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int NCFG   = 14,
  parameter int CFG_W  = 12
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [31:0]           S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [31:0]           S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  start,
  output logic                  wwrite,
  output logic                  bwrite,
  input  logic                  busy,
  input  logic                  done,
  output logic [NCFG*CFG_W-1:0] cfg,
  output logic                  irq
);

  logic              wr_en, wr_err, rd_en, rd_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, wr_strb_mask, rd_data;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_idx, rd_idx;
  logic              wr_ok, wr_cfg, start_req;

  logic                        start_q, start_d;
  logic                        wwrite_q, wwrite_d;
  logic                        bwrite_q, bwrite_d;
  logic [1:0]                  irq_en_q, irq_en_d;
  logic [1:0]                  irq_stat_q, irq_stat_d;
  logic                        irq_q, irq_d;
  logic [NCFG-1:0][CFG_W-1:0]  cfg_q, cfg_d;

  tiny_dnn_csr_axil #(.ADDR_W(ADDR_W)) u_axil (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .s_awaddr  (S_AXI_AWADDR),
    .s_awvalid (S_AXI_AWVALID),
    .s_awready (S_AXI_AWREADY),
    .s_wdata   (S_AXI_WDATA),
    .s_wstrb   (S_AXI_WSTRB),
    .s_wvalid  (S_AXI_WVALID),
    .s_wready  (S_AXI_WREADY),
    .s_bresp   (S_AXI_BRESP),
    .s_bvalid  (S_AXI_BVALID),
    .s_bready  (S_AXI_BREADY),
    .s_araddr  (S_AXI_ARADDR),
    .s_arvalid (S_AXI_ARVALID),
    .s_arready (S_AXI_ARREADY),
    .s_rdata   (S_AXI_RDATA),
    .s_rresp   (S_AXI_RRESP),
    .s_rvalid  (S_AXI_RVALID),
    .s_rready  (S_AXI_RREADY),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_err    (wr_err),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_err    (rd_err)
  );

  // Byte-offset bits are ignored; the read decode is computed every cycle
  // and only sampled on a read handshake.
  logic unused_lsb;
  assign unused_lsb = ^{wr_addr[1:0], rd_addr[1:0], rd_en};

  assign wr_idx       = 32'(wr_addr[ADDR_W-1:2]);
  assign rd_idx       = 32'(rd_addr[ADDR_W-1:2]);
  assign wr_strb_mask = strb_mask(wr_strb);

  assign start  = start_q;
  assign wwrite = wwrite_q;
  assign bwrite = bwrite_q;
  assign irq    = irq_q;
  assign cfg    = cfg_q;

  // Write decode: unmapped, STATUS, and CFG-while-busy are rejected
  always_comb begin
    wr_cfg = (wr_idx >= 32'(REG_CFG_BASE)) && (wr_idx < 32'(REG_CFG_BASE + NCFG));
    wr_err = (wr_idx >= 32'(REG_CFG_BASE + NCFG)) ||
             (wr_idx == 32'(REG_STATUS)) ||
             (wr_cfg && busy);
    wr_ok  = wr_en && !wr_err;
  end

  // Register file next-state; hardware sets of IRQ_STAT win over W1C
  always_comb begin
    logic [31:0] merged;
    logic [1:0]  stat_clr, stat_set;
    merged     = '0;
    wwrite_d   = wwrite_q;
    bwrite_d   = bwrite_q;
    irq_en_d   = irq_en_q;
    cfg_d      = cfg_q;
    stat_clr   = 2'b00;
    start_req  = wr_ok && (wr_idx == 32'(REG_CTRL)) && wr_strb[0] && wr_data[CTRL_START];
    start_d    = start_req && !busy;
    if (wr_ok && (wr_idx == 32'(REG_CTRL)) && wr_strb[0]) begin
      wwrite_d = wr_data[CTRL_WWRITE];
      bwrite_d = wr_data[CTRL_BWRITE];
    end
    if (wr_ok && (wr_idx == 32'(REG_IRQ_EN)) && wr_strb[0])
      irq_en_d = wr_data[1:0];
    if (wr_ok && (wr_idx == 32'(REG_IRQ_STAT)) && wr_strb[0])
      stat_clr = wr_data[1:0];
    stat_set                = 2'b00;
    stat_set[IRQ_DONE]      = done;
    stat_set[IRQ_START_ERR] = start_req && busy;
    irq_stat_d = (irq_stat_q & ~stat_clr) | stat_set;
    for (int i = 0; i < NCFG; i++) begin
      if (wr_ok && (wr_idx == 32'(REG_CFG_BASE + i))) begin
        merged   = (32'(cfg_q[i]) & ~wr_strb_mask) | (wr_data & wr_strb_mask);
        cfg_d[i] = merged[CFG_W-1:0];
      end
    end
    irq_d = |(irq_stat_q & irq_en_q);
  end

  // Read mux; reads see register state before any same-cycle write
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_idx == 32'(REG_CTRL)) begin
      rd_data[CTRL_WWRITE] = wwrite_q;
      rd_data[CTRL_BWRITE] = bwrite_q;
    end else if (rd_idx == 32'(REG_STATUS)) begin
      rd_data[0] = busy;
    end else if (rd_idx == 32'(REG_IRQ_EN)) begin
      rd_data[1:0] = irq_en_q;
    end else if (rd_idx == 32'(REG_IRQ_STAT)) begin
      rd_data[1:0] = irq_stat_q;
    end else if (rd_idx < 32'(REG_CFG_BASE + NCFG)) begin
      for (int i = 0; i < NCFG; i++)
        if (rd_idx == 32'(REG_CFG_BASE + i)) rd_data = 32'(cfg_q[i]);
    end else begin
      rd_err = 1'b1;
    end
  end

  // Register file state
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      start_q    <= 1'b0;
      wwrite_q   <= 1'b0;
      bwrite_q   <= 1'b0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
      cfg_q      <= '0;
    end else begin
      start_q    <= start_d;
      wwrite_q   <= wwrite_d;
      bwrite_q   <= bwrite_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      irq_q      <= irq_d;
      cfg_q      <= cfg_d;
    end
  end

endmodule
